// File: rtl/weight_mem_server.sv
// Streams one filter's weights from SRAM to the weight buffer through a 2-word staging FIFO.
// cur_mode encoding: 0 = MODE1, 1 = MODE2, 2 = MODE3, 3 = MODE4.
module weight_mem_server #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cur_mode,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              abort,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [63:0]       sram_rdata,
  input  logic              mem_req,
  output logic [63:0]       weight_data,
  output logic              mem_data_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] MODE1 = 2'd0;
  localparam logic [1:0] MODE2 = 2'd1;
  localparam logic [1:0] MODE3 = 2'd2;
  localparam logic [1:0] MODE4 = 2'd3;

  localparam int CNT_W  = 7;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [FCNT_W:0]   DEPTH_OCC = (FCNT_W + 1)'(FIFO_DEPTH);
  localparam logic [FCNT_W-1:0] DEPTH_CNT = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DONE
  } state_t;

  state_t            state_reg;
  logic [1:0]        mode_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [CNT_W-1:0]  issued_reg;
  logic [CNT_W-1:0]  xfer_reg;
  logic [FCNT_W-1:0] fifo_count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic              inflight_reg;
  logic [63:0]       fifo_mem [FIFO_DEPTH];

  logic [CNT_W-1:0]  target_words;
  logic              fetching;
  logic              fifo_valid;
  logic              pop;
  logic              push;
  logic              last_xfer;
  logic              pad_word;
  logic [FCNT_W:0]   occ_after_pop;
  logic [63:0]       head_word;

  always_comb begin
    target_words = 7'd88;
    unique case (mode_reg)
      MODE1, MODE2: target_words = 7'd88;
      MODE3:        target_words = 7'd19;
      MODE4:        target_words = 7'd11;
      default:      target_words = 7'd88;
    endcase
  end

  assign fetching   = rst_n && (state_reg == ST_FETCH);
  assign fifo_valid = fetching && (fifo_count_reg != '0);
  assign pop        = fifo_valid && mem_req;
  // Data returning in the abort cycle belongs to the cancelled fetch and is dropped.
  assign push       = fetching && inflight_reg && !abort;
  assign last_xfer  = pop && (xfer_reg == target_words - 1'b1);

  // Words already owned by the FIFO or on their way back, less the one leaving now.
  assign occ_after_pop = {1'b0, fifo_count_reg}
                       + {{FCNT_W{1'b0}}, inflight_reg}
                       - {{FCNT_W{1'b0}}, pop};

  assign sram_rd_en = fetching && !abort && mem_req
                    && (issued_reg < target_words)
                    && (occ_after_pop < DEPTH_OCC);
  assign sram_addr  = rst_n ? (base_reg + ADDR_W'(issued_reg)) : '0;

  assign head_word = fifo_mem[rd_ptr_reg];
  // In the 2-word-per-row modes the second word of each row only carries 24 valid bits.
  assign pad_word  = ((mode_reg == MODE1) || (mode_reg == MODE2)) && xfer_reg[0];

  always_comb begin
    weight_data = '0;
    if (fifo_valid) begin
      weight_data = pad_word ? {40'd0, head_word[23:0]} : head_word;
    end
  end

  assign mem_data_valid = fifo_valid;
  assign busy           = fetching;
  assign done           = rst_n && (state_reg == ST_DONE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state_reg      <= ST_IDLE;
      issued_reg     <= '0;
      xfer_reg       <= '0;
      fifo_count_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      inflight_reg   <= 1'b0;
      if (!rst_n) begin
        mode_reg <= MODE1;
        base_reg <= '0;
      end
    end else begin
      inflight_reg <= sram_rd_en;
      unique case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg      <= ST_FETCH;
            mode_reg       <= cur_mode;
            base_reg       <= base_addr;
            issued_reg     <= '0;
            xfer_reg       <= '0;
            fifo_count_reg <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
          end
        end
        ST_FETCH: begin
          if (sram_rd_en) begin
            issued_reg <= issued_reg + 1'b1;
          end
          if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            xfer_reg   <= xfer_reg + 1'b1;
          end
          fifo_count_reg <= fifo_count_reg + FCNT_W'(push) - FCNT_W'(pop);
          if (last_xfer) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_count_reg == DEPTH_CNT)));

endmodule

// File: tb/tb_weight_mem_server.sv
// Directed bench for weight_mem_server: a scoreboard queue of expected words per fetch,
// popped on every observed transfer; SRAM is a one-cycle-latency model.
module tb_weight_mem_server;

  localparam logic [1:0] MODE1 = 2'd0;
  localparam logic [1:0] MODE2 = 2'd1;
  localparam logic [1:0] MODE3 = 2'd2;
  localparam logic [1:0] MODE4 = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cur_mode;
  logic        start;
  logic [15:0] base_addr;
  logic        abort;
  logic        sram_rd_en;
  logic [15:0] sram_addr;
  logic [63:0] sram_rdata = '0;
  logic        mem_req;
  logic [63:0] weight_data;
  logic        mem_data_valid;
  logic        busy;
  logic        done;

  int          n_asserts = 0;
  int          n_fail = 0;
  bit          all_ones = 1'b0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  weight_mem_server #(.ADDR_W(16), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cur_mode       (cur_mode),
    .start          (start),
    .base_addr      (base_addr),
    .abort          (abort),
    .sram_rd_en     (sram_rd_en),
    .sram_addr      (sram_addr),
    .sram_rdata     (sram_rdata),
    .mem_req        (mem_req),
    .weight_data    (weight_data),
    .mem_data_valid (mem_data_valid),
    .busy           (busy),
    .done           (done)
  );

  function automatic logic [63:0] sram_word(input logic [15:0] a);
    return {a, a ^ 16'h5A5A, ~a, a + 16'h1234};
  endfunction

  always @(posedge clk) begin
    if (sram_rd_en) sram_rdata <= all_ones ? {64{1'b1}} : sram_word(sram_addr);
  end

  function automatic int words_for(input logic [1:0] m);
    if (m == MODE3) return 19;
    if (m == MODE4) return 11;
    return 88;
  endfunction

  function automatic logic [63:0] expected_word(input logic [1:0] m, input logic [15:0] a, input int idx);
    logic [63:0] w;
    w = all_ones ? {64{1'b1}} : sram_word(a);
    if (((m == MODE1) || (m == MODE2)) && (idx % 2 == 1)) w[63:24] = '0;
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_fetch(input string name, input logic [1:0] mode, input logic [15:0] base,
                           input bit toggle, input int abort_after, input int inject_j, input bit ones);
    int n, j, xfers, rds, dones, done_j, first_j;
    bit hold_armed, finished, aborted;
    logic [63:0] held;
    n = words_for(mode);
    all_ones = ones;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(expected_word(mode, base + 16'(i), i));
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b1; cur_mode = mode; base_addr = base; abort = 1'b0; mem_req = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    j = 0; xfers = 0; rds = 0; dones = 0; done_j = -1; first_j = -1;
    hold_armed = 1'b0; finished = 1'b0; aborted = 1'b0; held = '0;
    while (!finished && j < 400) begin
      mem_req = toggle ? (j % 2 == 0) : 1'b1;
      start = (j == inject_j);
      if (start) begin cur_mode = MODE1; base_addr = 16'h4000; end
      if (abort_after >= 0 && xfers == abort_after) begin
        abort = 1'b1; start = 1'b1; mem_req = 1'b0; aborted = 1'b1;
      end
      @(negedge clk);
      if (sram_rd_en) begin
        check($sformatf("%s addr[%0d]", name, rds), {48'd0, sram_addr}, {48'd0, base + 16'(rds)});
        rds++;
      end
      if (hold_armed) check($sformatf("%s hold", name), weight_data, held);
      hold_armed = mem_data_valid && !mem_req;
      held = weight_data;
      if (mem_data_valid && first_j < 0) first_j = j;
      if (mem_data_valid && mem_req) begin
        if (exp_q.size() == 0) check($sformatf("%s extra_word", name), 64'd1, 64'd0);
        else check($sformatf("%s word[%0d]", name, xfers), weight_data, exp_q.pop_front());
        xfers++;
      end
      if (done) begin dones++; done_j = j; finished = 1'b1; end
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      if (aborted) finished = 1'b1;
      j++;
    end
    if (aborted) begin
      mem_req = 1'b1;
      @(negedge clk);
      check($sformatf("%s valid_after_abort", name), {63'd0, mem_data_valid}, 64'd0);
      check($sformatf("%s busy_after_abort", name), {63'd0, busy}, 64'd0);
      check($sformatf("%s xfers_before_abort", name), 64'(xfers), 64'(abort_after));
      for (int k = 0; k < 4; k++) begin
        if (done) dones++;
        @(negedge clk);
      end
      check($sformatf("%s done_after_abort", name), 64'(dones), 64'd0);
    end else begin
      check($sformatf("%s done_seen", name), {63'd0, finished}, 64'd1);
      check($sformatf("%s xfers", name), 64'(xfers), 64'(n));
      check($sformatf("%s reads", name), 64'(rds), 64'(n));
      if (!toggle) begin
        check($sformatf("%s first_valid_cycle", name), 64'(first_j), 64'd2);
        check($sformatf("%s done_cycle", name), 64'(done_j), 64'(n + 2));
      end
      @(negedge clk);
      check($sformatf("%s done_one_cycle", name), {63'd0, done}, 64'd0);
      check($sformatf("%s busy_idle", name), {63'd0, busy}, 64'd0);
    end
    mem_req = 1'b0;
    $display("txn %s: mode=%0d base=0x%04h xfers=%0d reads=%0d done_cycle=%0d", name, mode, base, xfers, rds, done_j);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " rd_en"}, {63'd0, sram_rd_en}, 64'd0);
    check({tag, " addr"}, {48'd0, sram_addr}, 64'd0);
    check({tag, " data"}, weight_data, 64'd0);
    check({tag, " valid"}, {63'd0, mem_data_valid}, 64'd0);
    check({tag, " busy"}, {63'd0, busy}, 64'd0);
    check({tag, " done"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cur_mode = MODE1; base_addr = 16'h1234; mem_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    $display("txn reset: outputs checked while rst_n=0");

    run_fetch("mode3_basic", MODE3, 16'h0100, 1'b0, -1, -1, 1'b0);
    run_fetch("mode1_ones", MODE1, 16'h2000, 1'b0, -1, -1, 1'b1);
    run_fetch("mode4_toggle", MODE4, 16'h0500, 1'b1, -1, -1, 1'b0);
    run_fetch("mode2_wrap", MODE2, 16'hFFF0, 1'b0, -1, -1, 1'b0);
    run_fetch("mode1_abort", MODE1, 16'h0800, 1'b0, 30, -1, 1'b0);
    run_fetch("mode1_restart", MODE1, 16'h0800, 1'b0, -1, -1, 1'b0);
    run_fetch("mode3_start_in_fetch", MODE3, 16'h0200, 1'b0, -1, 5, 1'b0);

    // Reset in the middle of a fetch, then start in the first cycle after release.
    @(posedge clk); #1;
    start = 1'b1; cur_mode = MODE1; base_addr = 16'h0000; mem_req = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_quiet("reset_mid");
    @(posedge clk); #1;
    @(negedge clk);
    check_quiet("reset_mid_held");
    $display("txn reset_mid: reset applied during MODE1 fetch");
    run_fetch("mode4_after_reset", MODE4, 16'h3000, 1'b0, -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_mem_server.md
WEIGHT_MEM_SERVER -- requirements
Module: weight_mem_server

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the weight SRAM word-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the output staging depth in 64-bit words; it is fixed at 2.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cur_mode  input  OP_MODE  layer mode (MODE1..MODE4); sampled only on an accepted start.
REQ-006 start  input  1  one-cycle pulse that begins a filter fetch.
REQ-007 base_addr  input  ADDR_W  first SRAM word address of the filter; sampled with start.
REQ-008 abort  input  1  driven by the controller's free_weight_buffer; cancels the current fetch.
REQ-009 sram_rd_en  output  1  SRAM read strobe.
REQ-010 sram_addr  output  ADDR_W  SRAM read address.
REQ-011 sram_rdata  input  64  SRAM read data, valid exactly 1 cycle after sram_rd_en.
REQ-012 mem_req  input  1  request from the weight buffer; a word is transferred in any cycle where mem_data_valid and mem_req are both 1.
REQ-013 weight_data  output  64  word presented to the weight buffer.
REQ-014 mem_data_valid  output  1  weight_data is valid.
REQ-015 busy  output  1  high in the FETCH state.
REQ-016 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-017 FSM states: IDLE, FETCH, DONE.
  - IDLE->FETCH on start.
  - FETCH->DONE in the cycle the last word transfers.
  - DONE->IDLE unconditionally after 1 cycle.
REQ-018 On start in IDLE, the block SHALL latch mode and base_addr and clear the issued-word count, the transferred-word count and the FIFO.
REQ-019 start SHALL be ignored while the FSM is in FETCH or DONE.
REQ-020 Target word count N per mode:
  - MODE1 or MODE2: 88 (44 rows x 2 words).
  - MODE3: 19.
  - MODE4: 11.
REQ-021 In FETCH, sram_rd_en SHALL assert in a cycle iff all of the following hold:
  - mem_req = 1;
  - issued < N;
  - fifo_count + inflight - (transfer this cycle ? 1 : 0) < 2.
REQ-022 sram_addr SHALL equal (base_addr + issued) mod 2^ADDR_W; issued increments by 1 on each read.
REQ-023 Returned SRAM data SHALL be written into the FIFO tail 1 cycle after the read.
REQ-024 mem_data_valid SHALL equal FIFO not empty; weight_data SHALL be the FIFO head.
  - The head stays stable while mem_req = 0.
  - mem_data_valid is never asserted outside FETCH.
REQ-025 Padding, MODE1/MODE2 only: words with odd index (second word of each row) SHALL have bits 63:24 forced to 0 on output; bits 23:0 pass through.
  - In MODE3/MODE4 all words pass through unmodified.
REQ-026 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-027 FIFO overflow SHALL be impossible by construction of REQ-021; an assertion SHALL flag any push while fifo_count = 2 without a pop.
REQ-028 Latency: with mem_req held high, the first mem_data_valid SHALL occur 2 cycles after the start edge; sustained throughput is 1 word per cycle.
REQ-029 A deassertion of mem_req SHALL stop new reads; in-flight data is still captured.
REQ-030 Abort (any state) SHALL, on the next edge:
  - return the FSM to IDLE;
  - empty the FIFO;
  - zero all counts;
  - discard any in-flight read data;
  - leave done = 0.
REQ-031 abort and start in the same cycle: abort wins and start is ignored.
REQ-032 done SHALL be 1 only in the DONE state.

Reset
REQ-033 While rst_n = 0, the block SHALL hold the FSM in IDLE and the FIFO and counters at 0, and drive:
  - sram_rd_en = 0, sram_addr = 0;
  - weight_data = 0, mem_data_valid = 0;
  - busy = 0, done = 0.
REQ-034 Reset asserted mid-fetch SHALL behave as abort, and the block SHALL accept start in the first cycle after rst_n = 1.

Verification
REQ-035 MODE3, base_addr = 0x0100, mem_req held 1 -> 19 reads at 0x0100..0x0112; words delivered in order; done pulses once; total 21 cycles start-to-done.
REQ-036 MODE1, SRAM all 0xFFFF_FFFF_FFFF_FFFF -> 88 transfers; even-index words = all-ones; odd-index words = 0x0000_0000_00FF_FFFF.
REQ-037 MODE4 with mem_req toggling 1/0 every cycle -> exactly 11 transfers, none lost or duplicated; weight_data stable while mem_req = 0; no FIFO-overflow assertion fires.
REQ-038 MODE2, base_addr = 0xFFF0 -> address wraps from 0xFFFF to 0x0000; 88 words total.
REQ-039 Abort after 30 transfers in MODE1 -> mem_data_valid = 0 the next cycle; no done pulse; a new start then returns the first word at base_addr.
REQ-040 start pulsed during FETCH -> ignored; base_addr and mode unchanged; word count unaffected.
